// File: rtl/vmem_sched_pkg.sv
// Shared types and width helpers for the vector memory port scheduler.
package vmem_sched_pkg;

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} sched_state_t;

   // Requester index width; a single requester still needs one bit.
   function automatic int unsigned calc_id_w(input int unsigned num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   // Credit counter must hold the value MAX_OUTSTANDING itself.
   function automatic int unsigned calc_cred_w(input int unsigned max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
   parameter int unsigned NUM_REQ = 8,
   parameter int unsigned ID_W    = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               any,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx
);

   // Bit k of req_rot is requester (ptr + k) mod NUM_REQ.
   logic [NUM_REQ-1:0] req_rot;
   assign req_rot = NUM_REQ'({req, req} >> ptr);

   // Lowest set bit of the rotated vector, mapped back to an absolute index.
   always_comb begin
      int off;
      int sum;
      off = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) off = k;
      end
      any = |req;
      sum = int'(ptr) + off;
      if (sum >= int'(NUM_REQ)) sum = sum - int'(NUM_REQ);
      idx = ID_W'(sum);
      gnt = '0;
      if (any) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/vmem_port_scheduler.sv
// Shares one memory issue port among NUM_REQ requesters: round-robin grant,
// port locked for a whole burst, in-flight bursts limited by credits.
module vmem_port_scheduler
   import vmem_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ         = 8,
   parameter int unsigned ADDR_W          = 32,
   parameter int unsigned LEN_W           = 4,
   parameter int unsigned MAX_OUTSTANDING = 4,
   localparam int unsigned ID_W           = calc_id_w(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*LEN_W-1:0]  req_len,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      mem_valid,
   input  logic                      mem_ready,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [ID_W-1:0]           mem_id,
   output logic                      mem_last,
   input  logic                      rsp_done,
   output logic                      busy,
   output logic                      err_credit
);

   localparam int unsigned CRED_W = calc_cred_w(MAX_OUTSTANDING);
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_OUTSTANDING);

   sched_state_t       state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, id_q;
   logic [NUM_REQ-1:0] owner_q, req_ready_q;
   logic [CRED_W-1:0]  credits_q, credits_d;
   logic [LEN_W-1:0]   beat_cnt_q, len_q;
   logic [ADDR_W-1:0]  base_q;
   logic               err_credit_q;

   logic               pick_any;
   logic [NUM_REQ-1:0] pick_gnt;
   logic [ID_W-1:0]    pick_idx;
   logic [ADDR_W-1:0]  sel_addr;
   logic [LEN_W-1:0]   sel_len;
   logic               grant, beat_fire, burst_done, err_set;
   logic [ID_W-1:0]    next_ptr;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_pick (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .any (pick_any),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   assign grant      = (state_q == IDLE) && pick_any && (credits_q != '0);
   assign beat_fire  = mem_valid && mem_ready;
   assign burst_done = beat_fire && mem_last;
   assign next_ptr   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
   assign busy       = (state_q != IDLE);
   assign req_ready  = req_ready_q;
   assign err_credit = err_credit_q;

   // Mux the winning requester's base address and length.
   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (pick_idx == ID_W'(i)) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_len  = req_len[i*LEN_W +: LEN_W];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state: grant opens a burst, the last accepted beat closes it.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (grant)      state_d = BURST;
         BURST: if (burst_done) state_d = IDLE;
      endcase
   end

   // FSM outputs: memory port decoded from registered burst state, zero when idle.
   always_comb begin
      mem_valid = (state_q == BURST);
      mem_id    = mem_valid ? id_q : '0;
      mem_addr  = mem_valid ? base_q + ADDR_W'(beat_cnt_q) : '0;
      mem_last  = mem_valid && (beat_cnt_q == len_q);
   end

   // Credits: completion consumes, rsp_done returns; both together cancel out.
   always_comb begin
      credits_d = credits_q;
      err_set   = 1'b0;
      case ({burst_done, rsp_done})
         2'b10: credits_d = credits_q - CRED_W'(1);
         2'b01: begin
            if (credits_q == CRED_MAX) err_set = 1'b1;
            else                       credits_d = credits_q + CRED_W'(1);
         end
         default: ;
      endcase
   end

   // Burst context, beat counter, round-robin pointer, credits and status flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_q     <= '0;
         id_q         <= '0;
         owner_q      <= '0;
         base_q       <= '0;
         len_q        <= '0;
         beat_cnt_q   <= '0;
         req_ready_q  <= '0;
         credits_q    <= CRED_MAX;
         err_credit_q <= 1'b0;
      end else begin
         req_ready_q <= '0;
         credits_q   <= credits_d;
         if (err_set) err_credit_q <= 1'b1;
         if (grant) begin
            id_q       <= pick_idx;
            owner_q    <= pick_gnt;
            base_q     <= sel_addr;
            len_q      <= sel_len;
            beat_cnt_q <= '0;
         end else if (burst_done) begin
            req_ready_q <= owner_q;
            rr_ptr_q    <= next_ptr;
         end else if (beat_fire) begin
            beat_cnt_q <= beat_cnt_q + LEN_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_vmem_port_scheduler.sv
// Self-checking bench for vmem_port_scheduler: beat scoreboard plus per-scenario checks.
module tb_vmem_port_scheduler;

   logic         clk, reset;
   logic [7:0]   req_valid;
   logic [255:0] req_addr;
   logic [31:0]  req_len;
   logic [7:0]   req_ready;
   logic         mem_valid, mem_ready;
   logic [31:0]  mem_addr;
   logic [2:0]   mem_id;
   logic         mem_last, rsp_done, busy, err_credit;

   typedef struct packed {
      logic [2:0]  id;
      logic [31:0] addr;
      logic        last;
   } beat_t;

   beat_t exp_q[$];
   int compared   = 0;
   int mismatched = 0;

   vmem_port_scheduler #(
      .NUM_REQ         (8),
      .ADDR_W          (32),
      .LEN_W           (4),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_len    (req_len),
      .req_ready  (req_ready),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_id     (mem_id),
      .mem_last   (mem_last),
      .rsp_done   (rsp_done),
      .busy       (busy),
      .err_credit (err_credit)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1);
   end

   // Scoreboard: every accepted beat is popped and compared at the negative edge.
   always @(negedge clk) begin
      beat_t e;
      if (reset && mem_valid && mem_ready) begin
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_beat: got id=%0d addr=%h last=%0b, required no beat",
                     mem_id, mem_addr, mem_last);
         end else begin
            e = exp_q.pop_front();
            if ({mem_id, mem_addr, mem_last} !== {e.id, e.addr, e.last}) begin
               mismatched++;
               $display("FAIL beat: got id=%0d addr=%h last=%0b, required id=%0d addr=%h last=%0b",
                        mem_id, mem_addr, mem_last, e.id, e.addr, e.last);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input logic [2:0] id, input logic [31:0] addr, input logic last);
      beat_t b;
      b.id   = id;
      b.addr = addr;
      b.last = last;
      exp_q.push_back(b);
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] l);
      req_addr[i*32 +: 32] = a;
      req_len[i*4 +: 4]    = l;
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_len   = '0;
      mem_ready = 1'b0;
      rsp_done  = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   // Ticks until a req_ready pulse appears or the budget runs out (seen stays 0).
   task automatic wait_ready(input int max_cyc, output logic [7:0] seen);
      seen = '0;
      for (int i = 0; i < max_cyc; i++) begin
         tick();
         if (req_ready !== 8'h00) begin
            seen = req_ready;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      compared++;
      if ({mem_valid, mem_last, busy, err_credit} !== 4'b0) begin
         mismatched++;
         $display("FAIL reset_flags: got %b required 0000", {mem_valid, mem_last, busy, err_credit});
      end
      compared++;
      if ({req_ready, mem_id, mem_addr} !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs: got rdy=%h id=%0d addr=%h required all 0",
                  req_ready, mem_id, mem_addr);
      end
      compared++;
      if (dut.credits_q !== 3'd4) begin
         mismatched++;
         $display("FAIL reset_credits: got %0d required 4", dut.credits_q);
      end
      compared++;
      if (dut.rr_ptr_q !== 3'd0) begin
         mismatched++;
         $display("FAIL reset_rr_ptr: got %0d required 0", dut.rr_ptr_q);
      end
   endtask

   task automatic test_single();
      logic [7:0] seen;
      do_reset();
      set_req(3, 32'h100, 4'd2);
      push_beat(3'd3, 32'h100, 1'b0);
      push_beat(3'd3, 32'h101, 1'b0);
      push_beat(3'd3, 32'h102, 1'b1);
      mem_ready    = 1'b1;
      req_valid[3] = 1'b1;
      tick();
      compared++;
      if ({mem_valid, busy} !== 2'b11) begin
         mismatched++;
         $display("FAIL single_latency: got valid,busy=%b required 11", {mem_valid, busy});
      end
      wait_ready(10, seen);
      req_valid = '0;
      compared++;
      if (seen !== 8'h08) begin
         mismatched++;
         $display("FAIL single_ready: got %h required 08", seen);
      end
      tick();
      compared++;
      if (req_ready !== 8'h00) begin
         mismatched++;
         $display("FAIL single_pulse_width: got %h required 00", req_ready);
      end
      compared++;
      if (dut.credits_q !== 3'd3) begin
         mismatched++;
         $display("FAIL single_credits: got %0d required 3", dut.credits_q);
      end
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL single_drained: got %0d beats left required 0", exp_q.size());
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] seen, exp_rdy;
      int order[6] = '{0, 2, 5, 0, 2, 5};
      do_reset();
      set_req(0, 32'h1000, 4'd0);
      set_req(2, 32'h1020, 4'd0);
      set_req(5, 32'h1050, 4'd0);
      for (int i = 0; i < 6; i++) push_beat(3'(order[i]), 32'h1000 + 32'(order[i] * 16), 1'b1);
      mem_ready = 1'b1;
      req_valid = 8'b0010_0101;
      for (int i = 0; i < 6; i++) begin
         wait_ready(10, seen);
         exp_rdy = 8'h01 << order[i];
         compared++;
         if (seen !== exp_rdy) begin
            mismatched++;
            $display("FAIL rr_order[%0d]: got %h required %h", i, seen, exp_rdy);
         end
         if (i == 5) begin
            req_valid = '0;
         end else begin
            rsp_done = 1'b1;
            tick();
            rsp_done = 1'b0;
         end
      end
      tick();
      compared++;
      if (exp_q.size() != 0 || err_credit !== 1'b0) begin
         mismatched++;
         $display("FAIL rr_drained: got %0d beats left err=%b required 0 and 0",
                  exp_q.size(), err_credit);
      end
   endtask

   task automatic test_stall();
      logic [3:0]  pat = 4'b1001;
      logic [31:0] h_addr;
      logic [2:0]  h_id;
      logic        h_last, held, done;
      int          hs;
      do_reset();
      set_req(1, 32'h200, 4'd3);
      for (int i = 0; i < 4; i++) push_beat(3'd1, 32'h200 + 32'(i), i == 3);
      req_valid[1] = 1'b1;
      tick();
      hs   = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         mem_ready = pat[c % 4];
         if (mem_valid && mem_ready) hs++;
         held   = mem_valid && !mem_ready;
         h_addr = mem_addr;
         h_id   = mem_id;
         h_last = mem_last;
         tick();
         if (held) begin
            compared++;
            if ({mem_valid, mem_addr, mem_id, mem_last} !== {1'b1, h_addr, h_id, h_last}) begin
               mismatched++;
               $display("FAIL stall_hold: got v=%b a=%h id=%0d l=%b required v=1 a=%h id=%0d l=%b",
                        mem_valid, mem_addr, mem_id, mem_last, h_addr, h_id, h_last);
            end
         end
         if (req_ready !== 8'h00) begin
            done      = 1'b1;
            req_valid = '0;
         end
      end
      compared++;
      if (hs != 4 || !done) begin
         mismatched++;
         $display("FAIL stall_handshakes: got %0d (done=%b) required 4 (done=1)", hs, done);
      end
   endtask

   task automatic test_credits();
      logic [7:0] seen;
      do_reset();
      set_req(4, 32'h400, 4'd0);
      for (int i = 0; i < 5; i++) push_beat(3'd4, 32'h400, 1'b1);
      mem_ready    = 1'b1;
      req_valid[4] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_ready(10, seen);
         compared++;
         if (seen !== 8'h10) begin
            mismatched++;
            $display("FAIL credit_burst[%0d]: got %h required 10", i, seen);
         end
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         compared++;
         if ({busy, mem_valid} !== 2'b00) begin
            mismatched++;
            $display("FAIL credit_block[%0d]: got busy,valid=%b required 00", i, {busy, mem_valid});
         end
      end
      rsp_done = 1'b1;
      tick();
      rsp_done = 1'b0;
      compared++;
      if (mem_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL credit_return_cycle: got valid=%b required 0", mem_valid);
      end
      tick();
      compared++;
      if ({busy, mem_valid} !== 2'b11) begin
         mismatched++;
         $display("FAIL credit_reissue: got busy,valid=%b required 11", {busy, mem_valid});
      end
      wait_ready(10, seen);
      req_valid = '0;
      compared++;
      if (seen !== 8'h10 || exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL credit_fifth: got rdy=%h left=%0d required 10 and 0", seen, exp_q.size());
      end
   endtask

   task automatic test_same_edge();
      do_reset();
      set_req(6, 32'h600, 4'd0);
      push_beat(3'd6, 32'h600, 1'b1);
      mem_ready    = 1'b1;
      req_valid[6] = 1'b1;
      tick();
      rsp_done = 1'b1;
      tick();
      rsp_done  = 1'b0;
      req_valid = '0;
      compared++;
      if (req_ready !== 8'h40 || dut.credits_q !== 3'd4 || err_credit !== 1'b0) begin
         mismatched++;
         $display("FAIL same_edge: got rdy=%h cred=%0d err=%b required 40, 4, 0",
                  req_ready, dut.credits_q, err_credit);
      end
      rsp_done = 1'b1;
      tick();
      rsp_done = 1'b0;
      compared++;
      if (err_credit !== 1'b1 || dut.credits_q !== 3'd4) begin
         mismatched++;
         $display("FAIL err_credit_set: got err=%b cred=%0d required 1, 4",
                  err_credit, dut.credits_q);
      end
      repeat (3) tick();
      compared++;
      if (err_credit !== 1'b1) begin
         mismatched++;
         $display("FAIL err_credit_sticky: got %b required 1", err_credit);
      end
      do_reset();
      compared++;
      if (err_credit !== 1'b0) begin
         mismatched++;
         $display("FAIL err_credit_clear: got %b required 0", err_credit);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] seen;
      logic       bad;
      do_reset();
      set_req(2, 32'h50, 4'd0);
      push_beat(3'd2, 32'h50, 1'b1);
      mem_ready = 1'b1;
      req_valid = 8'h04;
      wait_ready(10, seen);
      req_valid = '0;
      tick();
      set_req(7, 32'h300, 4'd7);
      push_beat(3'd7, 32'h300, 1'b0);
      push_beat(3'd7, 32'h301, 1'b0);
      req_valid = 8'h80;
      repeat (3) tick();
      compared++;
      if (mem_addr !== 32'h302 || dut.rr_ptr_q !== 3'd3) begin
         mismatched++;
         $display("FAIL pre_reset: got addr=%h ptr=%0d required 302, 3", mem_addr, dut.rr_ptr_q);
      end
      reset = 1'b0;
      #1;
      compared++;
      if ({mem_valid, mem_last, busy, err_credit, req_ready, mem_id, mem_addr} !== '0) begin
         mismatched++;
         $display("FAIL mid_reset_outputs: got v=%b l=%b b=%b e=%b r=%h id=%0d a=%h required 0",
                  mem_valid, mem_last, busy, err_credit, req_ready, mem_id, mem_addr);
      end
      compared++;
      if (dut.credits_q !== 3'd4 || dut.rr_ptr_q !== 3'd0) begin
         mismatched++;
         $display("FAIL mid_reset_state: got cred=%0d ptr=%0d required 4, 0",
                  dut.credits_q, dut.rr_ptr_q);
      end
      req_valid = '0;
      @(posedge clk);
      #1 reset = 1'b1;
      bad = 1'b0;
      repeat (5) begin
         tick();
         if (req_ready !== 8'h00 || mem_valid !== 1'b0) bad = 1'b1;
      end
      compared++;
      if (bad !== 1'b0 || exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL mid_reset_no_pulse: got bad=%b left=%0d required 0 and 0", bad, exp_q.size());
      end
   endtask

   task automatic test_wrap();
      logic [7:0] seen;
      do_reset();
      set_req(1, 32'hFFFF_FFFF, 4'd1);
      push_beat(3'd1, 32'hFFFF_FFFF, 1'b0);
      push_beat(3'd1, 32'h0000_0000, 1'b1);
      mem_ready = 1'b1;
      req_valid = 8'h02;
      wait_ready(10, seen);
      req_valid = '0;
      compared++;
      if (seen !== 8'h02 || exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL wrap: got rdy=%h left=%0d required 02 and 0", seen, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_credits();
      test_same_edge();
      test_reset_mid();
      test_wrap();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
